// File: rtl/local_bias_pwrup_seq.sv
// Power-up sequencer for the local bias generator: qualifies the rails, releases pdb, waits for bias settle.
// Optional auto-retry from FAULT is enabled by defining LOCAL_BIAS_SEQ_RETRY_EN.
module local_bias_pwrup_seq #(
    parameter int SUPPLY_STABLE_CYC = 16,
    parameter int BIAS_SETTLE_CYC   = 64,
    parameter int RETRY_CYC         = 256,
    parameter int MAX_RETRY         = 3,
    parameter int CNT_W             = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  real        vddana_1p8,
    input  real        vddana_0p8,
    input  real        vssana,
    input  logic [1:0] atb_sel,
    input  logic       atb_req,
    output logic       pdb,
    output logic [1:0] atb_ena,
    output logic       bias_ready,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        OFF         = 3'd0,
        SUPPLY_WAIT = 3'd1,
        BIAS_ON     = 3'd2,
        READY       = 3'd3,
        FAULT       = 3'd4
    } state_t;

    // Terminal counts are one less than the cycle counts because the counter starts at zero.
    localparam logic [CNT_W-1:0] SUP_LAST = CNT_W'(SUPPLY_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(BIAS_SETTLE_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             supply_ok;
    logic             pdb_d, bias_ready_d, fault_d;
    logic [1:0]       atb_d;

`ifdef LOCAL_BIAS_SEQ_RETRY_EN
    localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RETRY_CYC - 1);
    localparam logic [1:0]       MAX_R    = 2'(MAX_RETRY);
    logic [1:0] retry_q, retry_d;
`else
    localparam int retry_cfg_unused = RETRY_CYC + MAX_RETRY;
`endif

    assign supply_ok = (vddana_1p8 >= 1.71) && (vddana_1p8 <= 1.89) &&
                       (vddana_0p8 >= 0.76) && (vddana_0p8 <= 0.84) &&
                       (vssana >= -0.05) && (vssana <= 0.05);

    assign state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef LOCAL_BIAS_SEQ_RETRY_EN
        retry_d = retry_q;
`endif
        if (!en) begin
            state_d = OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = SUPPLY_WAIT;
                    cnt_d   = '0;
                end
                SUPPLY_WAIT: begin
                    // A bad rail here only restarts qualification; it is not a fault.
                    if (!supply_ok) begin
                        cnt_d = '0;
                    end else if (cnt_q == SUP_LAST) begin
                        state_d = BIAS_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BIAS_ON: begin
                    if (!supply_ok) begin
                        state_d = FAULT;
                        cnt_d   = '0;
                    end else if (cnt_q == SET_LAST) begin
                        state_d = READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                READY: begin
                    if (!supply_ok) begin
                        state_d = FAULT;
                        cnt_d   = '0;
                    end
                end
                FAULT: begin
`ifdef LOCAL_BIAS_SEQ_RETRY_EN
                    if (retry_q != MAX_R) begin
                        if (cnt_q == RET_LAST) begin
                            state_d = SUPPLY_WAIT;
                            cnt_d   = '0;
                            retry_d = retry_q + 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
`else
                    state_d = FAULT;
`endif
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            endcase
        end

`ifdef LOCAL_BIAS_SEQ_RETRY_EN
        if (state_d == OFF) retry_d = '0;
        // fault persists through retries until the bias is ready again.
        fault_d = (state_d == FAULT) || (fault && state_d != READY && state_d != OFF);
`else
        fault_d = (state_d == FAULT);
`endif

        pdb_d        = (state_d == BIAS_ON) || (state_d == READY);
        bias_ready_d = (state_d == READY);

        if (state_d != READY)                   atb_d = 2'b00;
        else if (state_q == READY && atb_req)   atb_d = atb_sel;
        else                                    atb_d = atb_ena;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            pdb        <= 1'b0;
            bias_ready <= 1'b0;
            fault      <= 1'b0;
            atb_ena    <= 2'b00;
`ifdef LOCAL_BIAS_SEQ_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pdb        <= pdb_d;
            bias_ready <= bias_ready_d;
            fault      <= fault_d;
            atb_ena    <= atb_d;
`ifdef LOCAL_BIAS_SEQ_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_local_bias_pwrup_seq.sv
// Directed bench for local_bias_pwrup_seq with default parameters (16/64/256/3).
// The retry section only runs when LOCAL_BIAS_SEQ_RETRY_EN is defined.
module tb_local_bias_pwrup_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    real        vddana_1p8;
    real        vddana_0p8;
    real        vssana;
    logic [1:0] atb_sel;
    logic       atb_req;
    logic       pdb;
    logic [1:0] atb_ena;
    logic       bias_ready;
    logic       fault;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    local_bias_pwrup_seq dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .vddana_1p8 (vddana_1p8),
        .vddana_0p8 (vddana_0p8),
        .vssana     (vssana),
        .atb_sel    (atb_sel),
        .atb_req    (atb_req),
        .pdb        (pdb),
        .atb_ena    (atb_ena),
        .bias_ready (bias_ready),
        .fault      (fault),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle 1 ns past it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic good_rails();
        vddana_1p8 = 1.8;
        vddana_0p8 = 0.8;
        vssana     = 0.0;
    endtask

    task automatic check_outs(input string tag, input logic p, input logic [1:0] a,
                              input logic b, input logic f, input logic [2:0] s);
        check({tag, ".pdb"},   {31'd0, pdb},        {31'd0, p});
        check({tag, ".atb"},   {30'd0, atb_ena},    {30'd0, a});
        check({tag, ".ready"}, {31'd0, bias_ready}, {31'd0, b});
        check({tag, ".fault"}, {31'd0, fault},      {31'd0, f});
        check({tag, ".state"}, {29'd0, state},      {29'd0, s});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; atb_sel = 2'b00; atb_req = 1'b0;
        good_rails();
        tick(2);
        check_outs("reset", 1'b0, 2'b00, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;
        tick(1);
        check_outs("idle", 1'b0, 2'b00, 1'b0, 1'b0, 3'd0);

        // Power-up: en sampled at E, pdb at E+16, bias_ready at E+80.
        en = 1'b1;
        tick(1);
        check_outs("pu_E", 1'b0, 2'b00, 1'b0, 1'b0, 3'd1);
        tick(15);
        check("pu_pdb_early", {31'd0, pdb}, 32'd0);
        tick(1);
        check_outs("pu_pdb", 1'b1, 2'b00, 1'b0, 1'b0, 3'd2);
        tick(63);
        check("pu_rdy_early", {31'd0, bias_ready}, 32'd0);
        tick(1);
        check_outs("pu_rdy", 1'b1, 2'b00, 1'b1, 1'b0, 3'd3);

        // Testbus loads in READY and holds until the next request.
        atb_sel = 2'b11; atb_req = 1'b1;
        tick(1);
        atb_req = 1'b0; atb_sel = 2'b01;
        check("atb_load11", {30'd0, atb_ena}, 32'd3);
        tick(3);
        check("atb_hold", {30'd0, atb_ena}, 32'd3);
        atb_req = 1'b1;
        tick(1);
        atb_req = 1'b0;
        check("atb_load01", {30'd0, atb_ena}, 32'd1);

        // Rail boundaries are still good.
        vddana_1p8 = 1.89; vddana_0p8 = 0.76; vssana = -0.05;
        tick(2);
        check_outs("bound_hi", 1'b1, 2'b01, 1'b1, 1'b0, 3'd3);
        vddana_1p8 = 1.71; vddana_0p8 = 0.84; vssana = 0.05;
        tick(2);
        check_outs("bound_lo", 1'b1, 2'b01, 1'b1, 1'b0, 3'd3);

        // Rail fault in READY, then en low clears it.
        vddana_1p8 = 1.60;
        tick(1);
        check_outs("flt_ready", 1'b0, 2'b00, 1'b0, 1'b1, 3'd4);
        tick(5);
        check_outs("flt_sticky", 1'b0, 2'b00, 1'b0, 1'b1, 3'd4);
        en = 1'b0;
        tick(1);
        check_outs("flt_off", 1'b0, 2'b00, 1'b0, 1'b0, 3'd0);
        good_rails();

        // atb_req outside READY is ignored.
        atb_sel = 2'b11; atb_req = 1'b1;
        tick(1);
        atb_req = 1'b0;
        check("atb_ign_off", {30'd0, atb_ena}, 32'd0);

        // Glitch after 8 good cycles restarts qualification: pdb at E+25.
        en = 1'b1;
        tick(1);
        tick(8);
        vddana_0p8 = 0.70;
        tick(1);
        check_outs("glitch", 1'b0, 2'b00, 1'b0, 1'b0, 3'd1);
        good_rails();
        tick(15);
        check("glitch_pdb_early", {31'd0, pdb}, 32'd0);
        tick(1);
        check_outs("glitch_pdb", 1'b1, 2'b00, 1'b0, 1'b0, 3'd2);

        // Reset in BIAS_ON with en still high.
        tick(10);
        rst = 1'b1;
        tick(1);
        check_outs("rst_mid", 1'b0, 2'b00, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;
        tick(1);
        check("rst_rearm", {29'd0, state}, 32'd1);

        // Bad rail and en low at the same edge: OFF without fault.
        tick(16);
        check("bo_again", {29'd0, state}, 32'd2);
        vddana_1p8 = 1.95; en = 1'b0;
        tick(1);
        check_outs("flt_en_off", 1'b0, 2'b00, 1'b0, 1'b0, 3'd0);
        good_rails();

        // Reach READY again; atb_req coinciding with a rail fault.
        en = 1'b1;
        tick(81);
        check_outs("ready2", 1'b1, 2'b00, 1'b1, 1'b0, 3'd3);
        atb_sel = 2'b10; atb_req = 1'b1; vssana = 0.1;
        tick(1);
        atb_req = 1'b0;
        check_outs("flt_atb", 1'b0, 2'b00, 1'b0, 1'b1, 3'd4);

`ifdef LOCAL_BIAS_SEQ_RETRY_EN
        // Auto-retry after RETRY_CYC cycles in FAULT; fault stays set.
        tick(255);
        check("retry_wait", {29'd0, state}, 32'd4);
        tick(1);
        check("retry_state", {29'd0, state}, 32'd1);
        check("retry_fault", {31'd0, fault}, 32'd1);
        good_rails();
        tick(81);
        check_outs("retry_ready", 1'b1, 2'b00, 1'b1, 1'b0, 3'd3);
`endif

        en = 1'b0;
        tick(1);
        check_outs("final_off", 1'b0, 2'b00, 1'b0, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
